// File: rtl/video_timing_gen.sv
// Raster timing generator: free-running h/v counters over one frame, decoded
// into registered sync, data-enable, pixel coordinates and a frame-start strobe.
module video_timing_gen #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        En,
  output logic        Data_Req,
  output logic        De,
  output logic        Hsync,
  output logic        Vsync,
  output logic [11:0] Pixel_X,
  output logic [11:0] Pixel_Y,
  output logic        Frame_Start
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);

  logic [11:0] h_cnt_q, h_cnt_d;
  logic [11:0] v_cnt_q, v_cnt_d;
  logic        de_q, de_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic [11:0] px_q, px_d;
  logic [11:0] py_q, py_d;
  logic        fs_q, fs_d;

  logic act, hs, vs;

  // 13-bit compares keep a total of exactly 4096 from aliasing to zero.
  always_comb begin
    act = ({1'b0, h_cnt_q} < 13'(H_ACTIVE)) && ({1'b0, v_cnt_q} < 13'(V_ACTIVE));
    hs  = ({1'b0, h_cnt_q} >= 13'(HS_START)) && ({1'b0, h_cnt_q} < 13'(HS_END));
    vs  = ({1'b0, v_cnt_q} >= 13'(VS_START)) && ({1'b0, v_cnt_q} < 13'(VS_END));
  end

  // Data_Req is a one-way request with no ready: the pixel it announces is
  // consumed unconditionally on the next edge, when De rises for it.
  assign Data_Req = act & En;

  always_comb begin
    h_cnt_d = 12'd0;
    v_cnt_d = 12'd0;
    de_d    = 1'b0;
    hsync_d = ~HS_POL;
    vsync_d = ~VS_POL;
    px_d    = 12'd0;
    py_d    = 12'd0;
    fs_d    = 1'b0;
    if (En) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = 12'd0;
        v_cnt_d = (v_cnt_q == V_LAST) ? 12'd0 : v_cnt_q + 12'd1;
      end else begin
        h_cnt_d = h_cnt_q + 12'd1;
        v_cnt_d = v_cnt_q;
      end
      de_d    = act;
      hsync_d = hs ? HS_POL : ~HS_POL;
      vsync_d = vs ? VS_POL : ~VS_POL;
      px_d    = h_cnt_q;
      py_d    = v_cnt_q;
      fs_d    = (h_cnt_q == 12'd0) && (v_cnt_q == 12'd0);
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      h_cnt_q <= 12'd0;
      v_cnt_q <= 12'd0;
      de_q    <= 1'b0;
      hsync_q <= ~HS_POL;
      vsync_q <= ~VS_POL;
      px_q    <= 12'd0;
      py_q    <= 12'd0;
      fs_q    <= 1'b0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      de_q    <= de_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      px_q    <= px_d;
      py_q    <= py_d;
      fs_q    <= fs_d;
    end
  end

  assign De          = de_q;
  assign Hsync       = hsync_q;
  assign Vsync       = vsync_q;
  assign Pixel_X     = px_q;
  assign Pixel_Y     = py_q;
  assign Frame_Start = fs_q;

endmodule
